// File: rtl/core_pkg.sv
// Shared core types: data access widths, RISC-V exception causes and the
// data-memory responder state encoding.
package core_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } data_type_t;

  localparam logic [4:0] EXC_CAUSE_LOAD_ADDR_MISAL  = 5'h04;
  localparam logic [4:0] EXC_CAUSE_LOAD_FAULT       = 5'h05;
  localparam logic [4:0] EXC_CAUSE_STORE_ADDR_MISAL = 5'h06;
  localparam logic [4:0] EXC_CAUSE_STORE_FAULT      = 5'h07;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_resp_state_t;

  // Misalignment outranks range/type faults.
  function automatic logic [4:0] dmem_fault_cause(input logic we, input logic misaligned);
    if (misaligned) return we ? EXC_CAUSE_STORE_ADDR_MISAL : EXC_CAUSE_LOAD_ADDR_MISAL;
    else            return we ? EXC_CAUSE_STORE_FAULT      : EXC_CAUSE_LOAD_FAULT;
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for stores: write mask, replicated write data and
// alignment check for one data access.
module dmem_lane_ctrl
  import core_pkg::*;
(
  input  logic [1:0]  dtype,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] wdata,
  output logic [3:0]  we_mask,
  output logic [31:0] wdata_lane,
  output logic        misaligned
);

  always_comb begin
    we_mask    = '0;
    wdata_lane = '0;
    misaligned = 1'b0;
    case (dtype)
      BYTE: begin
        we_mask    = 4'b0001 << addr_lsb;
        wdata_lane = {4{wdata[7:0]}};
      end
      HALF_WORD: begin
        we_mask    = 4'b0011 << addr_lsb;
        wdata_lane = {2{wdata[15:0]}};
        misaligned = addr_lsb[0];
      end
      WORD: begin
        we_mask    = 4'hF;
        wdata_lane = wdata;
        misaligned = |addr_lsb;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data interface: word SRAM with byte
// lanes, fault checking and a fixed wait-state latency before rvalid.
module dmem_responder
  import core_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter logic [31:0] BASE_ADDR   = '0,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  dtype_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [4:0]  err_cause_o
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam dmem_resp_state_t AFTER_GRANT = (WAIT_CYCLES == 0) ? DMEM_RESP : DMEM_WAIT;

  dmem_resp_state_t state, state_next;
  logic [3:0]       cnt;
  logic             handshake;
  logic             in_range;
  logic             misaligned;
  logic             fault;
  logic [31:0]      offset;
  logic [31:0]      wdata_lane;
  logic [3:0]       we_mask;
  logic [AW-3:0]    idx;
  logic [31:0]      mem [WORDS];

  dmem_lane_ctrl u_lane (
    .dtype      (dtype_i),
    .addr_lsb   (addr_i[1:0]),
    .wdata      (wdata_i),
    .we_mask    (we_mask),
    .wdata_lane (wdata_lane),
    .misaligned (misaligned)
  );

  assign offset    = addr_i - BASE_ADDR;
  assign in_range  = offset < 32'(MEM_BYTES);
  assign idx       = offset[AW-1:2];
  assign fault     = misaligned | ~in_range | (dtype_i == 2'b11);
  assign handshake = req_i & gnt_o;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= DMEM_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DMEM_IDLE: if (req_i) state_next = AFTER_GRANT;
      DMEM_WAIT: if (cnt == '0) state_next = DMEM_RESP;
      DMEM_RESP: state_next = req_i ? AFTER_GRANT : DMEM_IDLE;
      default:   state_next = DMEM_IDLE;
    endcase
  end

  always_comb begin
    gnt_o    = 1'b0;
    rvalid_o = 1'b0;
    if (rst_n) begin
      gnt_o    = (state == DMEM_IDLE) || (state == DMEM_RESP);
      rvalid_o = (state == DMEM_RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                               cnt <= '0;
    else if (handshake)                       cnt <= CNT_LOAD;
    else if (state == DMEM_WAIT && cnt != '0) cnt <= cnt - 4'd1;
  end

  // The array is accessed on the grant edge straight from the handshake
  // inputs, so results are ready in the first post-grant cycle (needed when
  // WAIT_CYCLES is 0) and no request latch is required.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_o     <= '0;
      err_o       <= 1'b0;
      err_cause_o <= '0;
    end else if (handshake) begin
      err_o       <= fault;
      err_cause_o <= fault ? dmem_fault_cause(we_i, misaligned) : '0;
      rdata_o     <= fault ? '0 : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (handshake && we_i && !fault) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (we_mask[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

endmodule
